// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: size codes, FSM state encoding and request legality check for the LSU
package dm_lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RSP  = 2'b11
    } state_t;

    // Reserved size or an address not naturally aligned to the access size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_RSV) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// dm_lane_merge: merges store data into a memory word and extracts/extends load data by lane
module dm_lane_merge
    import dm_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic        sext_i,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_data_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [31:0] bmask;
    logic [31:0] hmask;
    logic [7:0]  b;
    logic [15:0] h;

    // Byte lane is addr[1:0], half lane is addr[1]; word accesses pass straight through.
    always_comb begin
        bsh       = {lane_i, 3'b000};
        hsh       = {lane_i[1], 4'b0000};
        bmask     = 32'h0000_00FF << bsh;
        hmask     = 32'h0000_FFFF << hsh;
        b         = 8'(word_i >> bsh);
        h         = 16'(word_i >> hsh);
        st_word_o = (size_i == SZ_B) ? ((word_i & ~bmask) | ({24'h0, wdata_i[7:0]} << bsh)) :
                    (size_i == SZ_H) ? ((word_i & ~hmask) | ({16'h0, wdata_i[15:0]} << hsh)) :
                    wdata_i;
        ld_data_o = (size_i == SZ_B) ? {{24{sext_i & b[7]}}, b} :
                    (size_i == SZ_H) ? {{16{sext_i & h[15]}}, h} :
                    word_i;
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator driving a word-wide data memory with read-modify-write sub-word stores
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_sext_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_dout_i
);

    state_t            state_q, state_d;
    logic              we_q, sext_q, err_q;
    logic [1:0]        size_q, lane_q;
    logic [31:0]       wdata_q, word_q, rdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              accept, bad;
    logic [31:0]       merge_word, st_word, ld_data;

    assign req_ready_o = (state_q == ST_IDLE) && rst_n_i;
    assign accept      = req_valid_i && req_ready_o;
    assign bad         = req_bad(req_size_i, req_addr_i[1:0]);
    assign merge_word  = (state_q == ST_RD) ? mem_dout_i : word_q;
    assign mem_addr_o  = maddr_q;
    assign mem_we_o    = (state_q == ST_WR);
    assign mem_din_o   = mem_we_o ? st_word : 32'h0;
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    dm_lane_merge u_merge (
        .word_i    (merge_word),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .wdata_i   (wdata_q),
        .sext_i    (sext_q),
        .st_word_o (st_word),
        .ld_data_o (ld_data)
    );

    // FSM state register; reset drops WR at once so a write is never left half done.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: errors skip memory, aligned word stores skip the read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = bad ? ST_RSP : (!req_we_i || req_size_i != SZ_W) ? ST_RD : ST_WR;
            ST_RD:   state_d = we_q ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture on accept, read word and load result capture in RD.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            maddr_q <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            sext_q  <= req_sext_i;
            err_q   <= bad;
            size_q  <= req_size_i;
            lane_q  <= req_addr_i[1:0];
            wdata_q <= req_wdata_i;
            rdata_q <= 32'h0;
            if (!bad) maddr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
        end else if (state_q == ST_RD) begin
            word_q <= mem_dout_i;
            if (!we_q) rdata_q <= ld_data;
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed vectors, corner sequences and random traffic against a byte-array memory model
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        mem_we;

    logic [31:0] mem_w [256];
    logic [7:0]  ref_mem [1024];
    int tests = 0;
    int fails = 0;
    int wcount = 0;

    always #5 clk = ~clk;

    dm_lsu dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_sext_i  (req_sext),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_addr_o  (mem_addr),
        .mem_din_o   (mem_din),
        .mem_we_o    (mem_we),
        .mem_dout_i  (mem_dout)
    );

    assign mem_dout = mem_w[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem_w[mem_addr[9:2]] <= mem_din;
            wcount <= wcount + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wd;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: memory as bytes, results from the access rules directly.
    task automatic model(input logic we, input logic [1:0] size, input logic sext, input logic [9:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                         output int lat, output int wd);
        int n = 1 << size;
        int a = int'(addr);
        logic [31:0] v = 32'h0;
        err = (size == 2'b11) || (a % n != 0);
        rd = 32'h0; lat = 1; wd = 0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
            wd = 1;
        end else begin
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
            lat = 2;
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic sext, input logic [9:0] addr,
                           input logic [31:0] wdata, input int stall, input bit intrude,
                           output logic [31:0] rd, output logic err, output int lat, output int wd);
        int w0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        w0 = wcount;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) check("mem_addr_aligned", 32'(mem_addr[1:0]), 32'd0);
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        err = rsp_err;
        if (intrude) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = addr & 10'h3FC; req_wdata = 32'h0BAD_0BAD;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, rd);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        wd = wcount - w0;
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        err, eerr;
        int          lat, elat, wd, ewd, bad_words;

        vt[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vt[2]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 32'h0,        1'b0, 2, 1};
        vt[3]  = '{1'b1, 2'b00, 1'b0, 10'h013, 32'hFFFFFFAA, 32'h0,        1'b0, 3, 1};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hAA223344, 1'b0, 2, 0};
        vt[5]  = '{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,        32'h000000AA, 1'b0, 2, 0};
        vt[6]  = '{1'b0, 2'b00, 1'b1, 10'h013, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 10'h020, 32'h0,        32'h0,        1'b0, 2, 1};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 10'h022, 32'h00008001, 32'h0,        1'b0, 3, 1};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 10'h020, 32'h0,        32'h80010000, 1'b0, 2, 0};
        vt[10] = '{1'b0, 2'b01, 1'b1, 10'h022, 32'h0,        32'hFFFF8001, 1'b0, 2, 0};
        vt[11] = '{1'b0, 2'b01, 1'b0, 10'h022, 32'h0,        32'h00008001, 1'b0, 2, 0};
        vt[12] = '{1'b1, 2'b01, 1'b0, 10'h021, 32'h00001234, 32'h0,        1'b1, 1, 0};
        vt[13] = '{1'b0, 2'b10, 1'b0, 10'h026, 32'h0,        32'h0,        1'b1, 1, 0};
        vt[14] = '{1'b1, 2'b11, 1'b0, 10'h030, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
        vt[15] = '{1'b1, 2'b10, 1'b0, 10'h3F8, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1};
        vt[16] = '{1'b1, 2'b10, 1'b0, 10'h3FC, 32'h01020304, 32'h0,        1'b0, 2, 1};
        vt[17] = '{1'b0, 2'b10, 1'b0, 10'h3F8, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
        vt[18] = '{1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0,        32'h01020304, 1'b0, 2, 0};
        vt[19] = '{1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0,        32'h00000001, 1'b0, 2, 0};
        vt[20] = '{1'b0, 2'b01, 1'b1, 10'h011, 32'h0,        32'h0,        1'b1, 1, 0};
        vt[21] = '{1'b0, 2'b00, 1'b1, 10'h012, 32'h0,        32'h00000022, 1'b0, 2, 0};

        for (int i = 0; i < 256; i++) mem_w[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
        req_addr = 10'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_din",   mem_din,        32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            run_req(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata, 0, 1'b0, rd, err, lat, wd);
            model(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata, erd, eerr, elat, ewd);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
            check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            check($sformatf("vec%0d_writes", i), wd, vt[i].wd);
        end
        check("mem_0x010", mem_w[10'h010 >> 2], 32'hAA223344);
        check("mem_0x020", mem_w[10'h020 >> 2], 32'h80010000);
        check("mem_0x3FC", mem_w[10'h3FC >> 2], 32'h01020304);
        check("mem_0x3F8", mem_w[10'h3F8 >> 2], 32'hCAFEF00D);
        check("mem_0x000", mem_w[0], 32'h0);

        run_req(1'b1, 2'b10, 1'b0, 10'h060, 32'h7E57AB1E, 0, 1'b0, rd, err, lat, wd);
        model(1'b1, 2'b10, 1'b0, 10'h060, 32'h7E57AB1E, erd, eerr, elat, ewd);
        run_req(1'b0, 2'b10, 1'b0, 10'h060, 32'h0, 5, 1'b1, rd, err, lat, wd);
        check("stall_load_rdata", rd, 32'h7E57AB1E);
        check("stall_intruder_writes", wd, 0);
        check("stall_mem_0x060", mem_w[10'h060 >> 2], 32'h7E57AB1E);

        run_req(1'b1, 2'b10, 1'b0, 10'h040, 32'h55667788, 0, 1'b0, rd, err, lat, wd);
        model(1'b1, 2'b10, 1'b0, 10'h040, 32'h55667788, erd, eerr, elat, ewd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 10'h041; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_mem_we", 32'(mem_we), 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("rstmid_no_write", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_idle", 32'(req_ready), 32'd1);
        check("rstmid_mem_0x040", mem_w[10'h040 >> 2], 32'h55667788);

        for (int i = 0; i < 300; i++) begin
            logic        we   = 1'($urandom);
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic        sext = 1'($urandom);
            logic [9:0]  addr = {($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, 7'($urandom)};
            logic [31:0] wdata = $urandom;
            if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~((10'd1 << size) - 10'd1);
            run_req(we, size, sext, addr, wdata, $urandom_range(0, 2), 1'b0, rd, err, lat, wd);
            model(we, size, sext, addr, wdata, erd, eerr, elat, ewd);
            check($sformatf("rnd%0d_rdata", i), rd, erd);
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
            check($sformatf("rnd%0d_lat", i), lat, elat);
            check($sformatf("rnd%0d_writes", i), wd, ewd);
        end

        bad_words = 0;
        for (int w = 0; w < 256; w++)
            if (mem_w[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) bad_words++;
        check("final_memory_bad_words", bad_words, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
